// File: rtl/tactile_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tactile_frame_packer
//  Purpose  : Captures one I/Q correlation matrix per integration period into
//             a ping-pong buffer. Each 32-bit accumulator is scaled and
//             saturated to a 16-bit sample. The matrix is then sent as a
//             framed byte stream over a valid/ready link:
//                 A5 5A seq drop {lo,hi}*2M csum
//             The correlator side is never stalled. A frame that starts while
//             no buffer is free is dropped whole and counted.
//  Revision : 1.0  initial release
// ============================================================================
module tactile_frame_packer #(
    parameter int DAC_CHANNELS = 16,
    parameter int ADC_CHANNELS = 16,
    parameter int IN_BITS      = 32,
    parameter int SAMPLE_SHIFT = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic [$clog2(DAC_CHANNELS)-1:0] in_dac,
    input  logic [$clog2(ADC_CHANNELS)-1:0] in_adc,
    input  logic                            in_phase,
    input  logic [IN_BITS-1:0]              in_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic [7:0]                      tx_data,
    output logic [7:0]                      frame_seq,
    output logic [7:0]                      drop_count,
    output logic                            busy
);

    localparam int DAC_W = $clog2(DAC_CHANNELS);
    localparam int ADC_W = $clog2(ADC_CHANNELS);
    localparam int M     = DAC_CHANNELS * ADC_CHANNELS;
    localparam int DEPTH = 2 * M;              // samples per buffer
    localparam int AW    = $clog2(DEPTH);      // equals 1 + ADC_W + DAC_W

    localparam logic [DAC_W-1:0] C_DAC_LAST = DAC_W'(DAC_CHANNELS - 1);
    localparam logic [ADC_W-1:0] C_ADC_LAST = ADC_W'(ADC_CHANNELS - 1);

    localparam logic signed [IN_BITS-1:0] C_SAT_MAX = IN_BITS'(32767);
    localparam logic signed [IN_BITS-1:0] C_SAT_MIN = -(IN_BITS'(32768));

    typedef enum logic [1:0] {
        BUF_FREE    = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_HDR0    = 3'd1,
        RD_HDR1    = 3'd2,
        RD_SEQ     = 3'd3,
        RD_DROP    = 3'd4,
        RD_SAMP_LO = 3'd5,
        RD_SAMP_HI = 3'd6,
        RD_CSUM    = 3'd7
    } rd_state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    buf_state_t     buf_st_q [2];
    buf_state_t     buf_st_d [2];
    logic           wr_act_q, wr_act_d;     // a buffer is currently FILLING
    logic           wr_buf_q, wr_buf_d;     // which buffer the writer owns
    logic [7:0]     drop_count_q, drop_count_d;

    logic [1:0]     q_cnt_q;                // FULL buffers waiting for the reader
    logic           q0_q, q1_q;             // queue slots, q0 is the oldest

    rd_state_t      rd_state_q, rd_state_d;
    logic           rd_buf_q;
    logic [AW-1:0]  raddr_q;                // next sample address to fetch
    logic [15:0]    rdat_q;                 // registered memory read data
    logic [15:0]    samp_q;                 // sample currently being sent
    logic [7:0]     csum_q;
    logic [7:0]     drop_lat_q;
    logic [7:0]     seq_q;
    logic [7:0]     frame_seq_q;

    logic [15:0]    mem_q [2*DEPTH];

    logic [AW-1:0]               w_waddr;
    logic                        w_start;
    logic                        w_last;
    logic                        w_rel;
    logic                        w_we;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_head;
    logic                        w_q_avail;
    logic                        w_acc;
    logic signed [IN_BITS-1:0]   w_shifted;
    logic [15:0]                 w_sample;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    // Channel counts are powers of two, so the word address is a concatenation.
    assign w_waddr = {in_phase, in_adc, in_dac};
    assign w_start = in_valid && !in_phase && (in_adc == '0) && (in_dac == '0);
    assign w_last  = in_phase && (in_adc == C_ADC_LAST) && (in_dac == C_DAC_LAST);

    // The reader releases its buffer when the checksum byte is accepted.
    assign w_rel   = (rd_state_q == RD_CSUM) && tx_ready;

    assign w_shifted = $signed(in_data) >>> SAMPLE_SHIFT;

    // Saturate the scaled accumulator into a signed 16-bit sample
    always_comb begin
        if (w_shifted > C_SAT_MAX) begin
            w_sample = 16'h7FFF;
        end else if (w_shifted < C_SAT_MIN) begin
            w_sample = 16'h8000;
        end else begin
            w_sample = w_shifted[15:0];
        end
    end

    // ------------------------------------------------------------------
    // Writer: buffer ownership, frame start / completion, drop counting
    // ------------------------------------------------------------------
    // Next-state for buffer ownership and the writer
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            buf_st_d[i] = buf_st_q[i];
        end
        wr_act_d     = wr_act_q;
        wr_buf_d     = wr_buf_q;
        drop_count_d = drop_count_q;
        w_we         = 1'b0;
        w_push       = 1'b0;

        // The release is applied first. A buffer freed this cycle can then
        // take a frame that starts in the same cycle.
        if (w_rel) begin
            buf_st_d[rd_buf_q] = BUF_FREE;
        end

        if (w_start) begin
            // Any partially filled buffer is abandoned before claiming.
            for (int i = 0; i < 2; i++) begin
                if (buf_st_q[i] == BUF_FILLING) begin
                    buf_st_d[i] = BUF_FREE;
                end
            end
            if (buf_st_d[0] == BUF_FREE) begin
                buf_st_d[0] = BUF_FILLING;
                wr_buf_d    = 1'b0;
                wr_act_d    = 1'b1;
                w_we        = 1'b1;
            end else if (buf_st_d[1] == BUF_FREE) begin
                buf_st_d[1] = BUF_FILLING;
                wr_buf_d    = 1'b1;
                wr_act_d    = 1'b1;
                w_we        = 1'b1;
            end else begin
                // Both buffers are full: discard until the next frame start.
                wr_act_d     = 1'b0;
                drop_count_d = drop_count_q + 8'd1;
            end
        end else if (in_valid && wr_act_q) begin
            w_we = 1'b1;
            if (w_last) begin
                buf_st_d[wr_buf_q] = BUF_FULL;
                wr_act_d           = 1'b0;
                w_push             = 1'b1;
            end
        end
    end

    // Writer state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                buf_st_q[i] <= BUF_FREE;
            end
            wr_act_q     <= 1'b0;
            wr_buf_q     <= 1'b0;
            drop_count_q <= 8'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                buf_st_q[i] <= buf_st_d[i];
            end
            wr_act_q     <= wr_act_d;
            wr_buf_q     <= wr_buf_d;
            drop_count_q <= drop_count_d;
        end
    end

    // ------------------------------------------------------------------
    // Completion-order queue of FULL buffers (at most two entries)
    // ------------------------------------------------------------------
    // A buffer completing in the same cycle as a pop is passed straight through.
    assign w_head    = (q_cnt_q != 2'd0) ? q0_q : wr_buf_q;
    assign w_q_avail = (q_cnt_q != 2'd0) || w_push;

    // Push/pop bookkeeping for the FULL-buffer queue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_cnt_q <= 2'd0;
            q0_q    <= 1'b0;
            q1_q    <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (q_cnt_q == 2'd0) begin
                        q0_q <= wr_buf_q;
                    end else begin
                        q1_q <= wr_buf_q;
                    end
                    q_cnt_q <= q_cnt_q + 2'd1;
                end
                2'b01: begin
                    q0_q    <= q1_q;
                    q_cnt_q <= q_cnt_q - 2'd1;
                end
                2'b11: begin
                    if (q_cnt_q == 2'd1) begin
                        q0_q <= wr_buf_q;
                    end else if (q_cnt_q == 2'd2) begin
                        q0_q <= q1_q;
                        q1_q <= wr_buf_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sample memory: both buffers share one array, indexed by buffer bit
    // ------------------------------------------------------------------
    // Sample writes and the read-ahead fetch for the reader
    always_ff @(posedge clk) begin
        if (w_we) begin
            mem_q[{wr_buf_d, w_waddr}] <= w_sample;
        end
        rdat_q <= mem_q[{rd_buf_q, raddr_q}];
    end

    // ------------------------------------------------------------------
    // Reader FSM
    // ------------------------------------------------------------------
    assign w_acc = (rd_state_q != RD_IDLE) && tx_ready;

    // Reader next-state and queue pop
    always_comb begin
        rd_state_d = rd_state_q;
        w_pop      = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (q_cnt_q != 2'd0) begin
                    rd_state_d = RD_HDR0;
                    w_pop      = 1'b1;
                end
            end
            RD_HDR0:    if (tx_ready) rd_state_d = RD_HDR1;
            RD_HDR1:    if (tx_ready) rd_state_d = RD_SEQ;
            RD_SEQ:     if (tx_ready) rd_state_d = RD_DROP;
            RD_DROP:    if (tx_ready) rd_state_d = RD_SAMP_LO;
            RD_SAMP_LO: if (tx_ready) rd_state_d = RD_SAMP_HI;
            RD_SAMP_HI: begin
                // raddr_q runs one ahead of the sample being sent, so it
                // wraps to zero exactly when the last sample is on the wire.
                if (tx_ready) begin
                    rd_state_d = (raddr_q == '0) ? RD_CSUM : RD_SAMP_LO;
                end
            end
            RD_CSUM: begin
                if (tx_ready) begin
                    if (w_q_avail) begin
                        rd_state_d = RD_HDR0;
                        w_pop      = 1'b1;
                    end else begin
                        rd_state_d = RD_IDLE;
                    end
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Output byte selection. Every source is a register, so the byte holds
    // steady while the sink stalls.
    always_comb begin
        tx_data = 8'h00;
        case (rd_state_q)
            RD_HDR0:    tx_data = 8'hA5;
            RD_HDR1:    tx_data = 8'h5A;
            RD_SEQ:     tx_data = seq_q;
            RD_DROP:    tx_data = drop_lat_q;
            RD_SAMP_LO: tx_data = samp_q[7:0];
            RD_SAMP_HI: tx_data = samp_q[15:8];
            RD_CSUM:    tx_data = csum_q;
            default:    tx_data = 8'h00;
        endcase
    end

    // Reader state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q  <= RD_IDLE;
            rd_buf_q    <= 1'b0;
            raddr_q     <= '0;
            samp_q      <= 16'd0;
            csum_q      <= 8'd0;
            drop_lat_q  <= 8'd0;
            seq_q       <= 8'd0;
            frame_seq_q <= 8'd0;
        end else begin
            rd_state_q <= rd_state_d;

            if (w_acc) begin
                case (rd_state_q)
                    RD_HDR0: drop_lat_q <= drop_count_q;
                    RD_SEQ, RD_DROP, RD_SAMP_LO, RD_SAMP_HI:
                        csum_q <= csum_q + tx_data;
                    default: begin
                    end
                endcase

                if ((rd_state_q == RD_DROP) ||
                    ((rd_state_q == RD_SAMP_HI) && (raddr_q != '0))) begin
                    samp_q  <= rdat_q;
                    raddr_q <= raddr_q + AW'(1);
                end

                if (rd_state_q == RD_CSUM) begin
                    frame_seq_q <= seq_q;
                    seq_q       <= seq_q + 8'd1;
                end
            end

            // Starting a frame: take the oldest FULL buffer and fetch sample 0.
            if (w_pop) begin
                rd_buf_q <= w_head;
                raddr_q  <= '0;
                csum_q   <= 8'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_valid   = (rd_state_q != RD_IDLE);
    assign busy       = (rd_state_q != RD_IDLE);
    assign frame_seq  = frame_seq_q;
    assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tactile_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tactile_frame_packer
//  Purpose  : Directed self-checking bench for tactile_frame_packer at the
//             default 16x16 configuration (1029-byte frames).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tactile_frame_packer;

    localparam int DEPTH = 512;
    localparam int FLEN  = 4 + 2 * DEPTH + 1;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        in_valid   = 1'b0;
    logic [3:0]  in_dac     = 4'd0;
    logic [3:0]  in_adc     = 4'd0;
    logic        in_phase   = 1'b0;
    logic [31:0] in_data    = 32'd0;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [7:0]  frame_seq;
    logic [7:0]  drop_count;
    logic        busy;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int          stall_err  = 0;
    logic [7:0]  rxq [$];
    bit          bp_mode    = 1'b0;
    bit          ready_level = 1'b0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'd0;

    tactile_frame_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_dac     (in_dac),
        .in_adc     (in_adc),
        .in_phase   (in_phase),
        .in_data    (in_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .frame_seq  (frame_seq),
        .drop_count (drop_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Sink ready: fixed level, or about 30 % stall cycles in backpressure mode
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) tx_ready = ($urandom_range(0, 99) >= 30);
            else         tx_ready = ready_level;
        end
    end

    // Byte capture and stall-stability monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || (tx_data !== prev_data))) stall_err++;
            if (tx_valid && tx_ready) rxq.push_back(tx_data);
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Input pattern: 0 = ramp, 1 = reversed ramp, 2 = saturation corners then ramp
    function automatic logic [31:0] in_word(input int pat, input int a);
        case (pat)
            0: return 32'(a) << 8;
            1: return 32'(DEPTH - 1 - a) << 8;
            default: begin
                case (a)
                    0:       return 32'h7FFF_FFFF;
                    1:       return 32'h8000_0000;
                    2:       return 32'hFFFF_FF00;
                    3:       return 32'h0000_7FFF;
                    default: return 32'(a) << 8;
                endcase
            end
        endcase
    endfunction

    // Hand-derived 16-bit samples for each pattern
    function automatic logic [15:0] exp_sample(input int pat, input int a);
        case (pat)
            0: return 16'(a);
            1: return 16'(DEPTH - 1 - a);
            default: begin
                case (a)
                    0:       return 16'h7FFF;
                    1:       return 16'h8000;
                    2:       return 16'hFFFF;
                    3:       return 16'h007F;
                    default: return 16'(a);
                endcase
            end
        endcase
    endfunction

    task automatic put(input int a, input logic [31:0] d);
        in_valid = 1'b1;
        in_phase = a[8];
        in_adc   = a[7:4];
        in_dac   = a[3:0];
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int pat);
        for (int a = 0; a < DEPTH; a++) put(a, in_word(pat, a));
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while ((rxq.size() < n) && (k < budget)) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (rxq.size() < n) check_value("rx_timeout", 32'(rxq.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input int base, input logic [7:0] seq,
                               input logic [7:0] drop, input int pat);
        int          nbad;
        logic [7:0]  sum;
        logic [15:0] s;
        if (rxq.size() < base + FLEN) begin
            check_value({tag, "_short"}, 32'(rxq.size()), 32'(base + FLEN));
            return;
        end
        check_value({tag, "_hdr0"}, 32'(rxq[base]),     32'h0A5);
        check_value({tag, "_hdr1"}, 32'(rxq[base + 1]), 32'h05A);
        check_value({tag, "_seq"},  32'(rxq[base + 2]), 32'(seq));
        check_value({tag, "_drop"}, 32'(rxq[base + 3]), 32'(drop));
        nbad = 0;
        sum  = seq + drop;
        for (int i = 0; i < DEPTH; i++) begin
            s = exp_sample(pat, i);
            if (rxq[base + 4 + 2 * i] !== s[7:0])  nbad++;
            if (rxq[base + 5 + 2 * i] !== s[15:8]) nbad++;
            sum = sum + s[7:0] + s[15:8];
        end
        check_value({tag, "_samples_bad"}, 32'(nbad), 32'd0);
        check_value({tag, "_csum"}, 32'(rxq[base + FLEN - 1]), 32'(sum));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;

        // ---------------- reset values ----------------
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_tx_valid",   32'(tx_valid),   32'd0);
        check_value("rst_tx_data",    32'(tx_data),    32'd0);
        check_value("rst_frame_seq",  32'(frame_seq),  32'd0);
        check_value("rst_drop_count", 32'(drop_count), 32'd0);
        check_value("rst_busy",       32'(busy),       32'd0);
        rst_n = 1'b1;
        ready_level = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- single ramp frame + latency ----------------
        base = rxq.size();
        for (int a = 0; a < DEPTH; a++) put(a, in_word(0, a));
        check_value("lat_n1_valid", 32'(tx_valid), 32'd0);
        @(posedge clk);
        #1;
        check_value("lat_n2_valid", 32'(tx_valid), 32'd1);
        check_value("lat_n2_data",  32'(tx_data),  32'h0A5);
        check_value("lat_busy",     32'(busy),     32'd1);
        wait_rx(base + FLEN, 3000);
        repeat (20) @(posedge clk);
        #1;
        check_value("ramp_len", 32'(rxq.size() - base), 32'(FLEN));
        check_frame("ramp", base, 8'd0, 8'd0, 0);
        check_value("ramp_csum_const", 32'(rxq[base + FLEN - 1]), 32'd0);
        check_value("ramp_frame_seq",  32'(frame_seq), 32'd0);
        check_value("ramp_busy_done",  32'(busy),      32'd0);

        // ---------------- saturation ----------------
        base = rxq.size();
        send_frame(2);
        wait_rx(base + FLEN, 3000);
        check_frame("sat", base, 8'd1, 8'd0, 2);
        check_value("sat_s0", 32'({rxq[base + 5],  rxq[base + 4]}),  32'h7FFF);
        check_value("sat_s1", 32'({rxq[base + 7],  rxq[base + 6]}),  32'h8000);
        check_value("sat_s2", 32'({rxq[base + 9],  rxq[base + 8]}),  32'hFFFF);
        check_value("sat_s3", 32'({rxq[base + 11], rxq[base + 10]}), 32'h007F);

        // ---------------- backpressure ----------------
        base = rxq.size();
        bp_mode = 1'b1;
        send_frame(0);
        wait_rx(base + FLEN, 8000);
        bp_mode = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_frame("bp", base, 8'd2, 8'd0, 0);
        check_value("bp_stall_stable", 32'(stall_err), 32'd0);
        check_value("bp_frame_seq", 32'(frame_seq), 32'd2);

        // ---------------- overflow ----------------
        do_reset();
        ready_level = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        base = rxq.size();
        send_frame(0);
        send_frame(1);
        send_frame(0);
        repeat (5) @(posedge clk);
        #1;
        check_value("ovf_drop_count", 32'(drop_count), 32'd1);
        check_value("ovf_stalled_valid", 32'(tx_valid), 32'd1);
        check_value("ovf_stalled_data",  32'(tx_data),  32'h0A5);
        check_value("ovf_nothing_sent",  32'(rxq.size() - base), 32'd0);
        ready_level = 1'b1;
        wait_rx(base + 2 * FLEN, 5000);
        repeat (20) @(posedge clk);
        #1;
        check_value("ovf_len", 32'(rxq.size() - base), 32'(2 * FLEN));
        check_frame("ovf_f0", base,        8'd0, 8'd1, 0);
        check_frame("ovf_f1", base + FLEN, 8'd1, 8'd1, 1);
        check_value("ovf_frame_seq", 32'(frame_seq), 32'd1);
        check_value("ovf_stall_stable", 32'(stall_err), 32'd0);

        // ---------------- aborted frame ----------------
        do_reset();
        base = rxq.size();
        for (int a = 0; a < 100; a++) put(a, in_word(0, a));
        send_frame(1);
        wait_rx(base + FLEN, 3000);
        repeat (40) @(posedge clk);
        #1;
        check_value("abort_len", 32'(rxq.size() - base), 32'(FLEN));
        check_frame("abort", base, 8'd0, 8'd0, 1);
        check_value("abort_drop_count", 32'(drop_count), 32'd0);

        // ---------------- reset mid-transmission ----------------
        base = rxq.size();
        send_frame(0);
        wait_rx(base + 500, 3000);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(tx_valid), 32'd0);
        check_value("mid_rst_busy",  32'(busy),     32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("post_rst_valid",      32'(tx_valid),   32'd0);
        check_value("post_rst_data",       32'(tx_data),    32'd0);
        check_value("post_rst_frame_seq",  32'(frame_seq),  32'd0);
        check_value("post_rst_drop_count", 32'(drop_count), 32'd0);
        base = rxq.size();
        repeat (30) @(posedge clk);
        #1;
        check_value("post_rst_no_resume", 32'(rxq.size() - base), 32'd0);
        send_frame(0);
        wait_rx(base + FLEN, 3000);
        check_frame("post_rst", base, 8'd0, 8'd0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
